// File: rtl/gb_regfile_ctx.sv
// SM83 register file with integrated increment/decrement unit and a
// multi-cycle context stack that saves/restores AF/BC/DE/HL.
`timescale 1ns/1ps
module gb_regfile_ctx #(
    parameter int unsigned CTX_DEPTH = 4,
    parameter int unsigned LVL_W     = $clog2(CTX_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       rd_r_sel,
    output logic [7:0]       rd_r_data,
    input  logic [2:0]       rd_rr_sel,
    output logic [15:0]      rd_rr_data,
    input  logic             wr_r_en,
    input  logic [3:0]       wr_r_sel,
    input  logic [7:0]       wr_r_data,
    input  logic             wr_rr_en,
    input  logic [2:0]       wr_rr_sel,
    input  logic [15:0]      wr_rr_data,
    input  logic             flags_we,
    input  logic [3:0]       flags_mask_n,
    input  logic [3:0]       flags_in,
    input  logic             idu_en,
    input  logic [2:0]       idu_sel,
    input  logic [1:0]       idu_op,
    output logic [15:0]      idu_addr,
    input  logic             ctx_save_req,
    input  logic             ctx_restore_req,
    output logic             ctx_busy,
    output logic             ctx_done,
    output logic             ctx_err,
    output logic             ctx_full,
    output logic             ctx_empty,
    output logic [LVL_W-1:0] ctx_level,
    output logic [7:0]       A_out,
    output logic [3:0]       flags_out
);

    // Stack index width; storage is rounded up to a power of two so the
    // level-derived index always matches the array range.
    localparam int unsigned IDX_W = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
    localparam int unsigned STK_N = 1 << IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StSave,
        StRestore
    } ctx_state_e;

    // Architectural registers (F low nibble is always stored as 0)
    logic [15:0] r_af, r_bc, r_de, r_hl, r_sp, r_pc, r_wz;
    logic [15:0] w_af_d, w_bc_d, w_de_d, w_hl_d, w_sp_d, w_pc_d, w_wz_d;

    // Context FSM state
    ctx_state_e       r_state, w_state_d;
    logic [1:0]       r_k, w_k_d;
    logic [LVL_W-1:0] r_level, w_level_d;
    logic             r_done, w_done_d;
    logic             r_err, w_err_d;

    logic [15:0] r_stack [STK_N][4];

    logic [15:0]      w_pair [8];
    logic             w_idle;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level_m1;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic [15:0]      w_stk_rd;
    logic [15:0]      w_idu_res;
    logic             w_idu_wr;

    assign w_idle     = (r_state == StIdle);
    assign w_full     = (r_level == LVL_W'(CTX_DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_level_m1 = r_level - LVL_W'(1);
    assign w_wr_idx   = r_level[IDX_W-1:0];
    assign w_rd_idx   = w_level_m1[IDX_W-1:0];
    assign w_stk_rd   = r_stack[w_rd_idx][r_k];

    // Pair view used by reads, the IDU and context saves
    always_comb begin
        w_pair[0] = {r_af[15:4], 4'b0000};
        w_pair[1] = r_bc;
        w_pair[2] = r_de;
        w_pair[3] = r_hl;
        w_pair[4] = r_sp;
        w_pair[5] = r_pc;
        w_pair[6] = r_wz;
        w_pair[7] = 16'h0000;
    end

    assign rd_rr_data = w_pair[rd_rr_sel];
    assign idu_addr   = w_pair[idu_sel];

    // 8-bit combinational read mux
    always_comb begin
        rd_r_data = 8'h00;
        case (rd_r_sel)
            4'd0:    rd_r_data = r_af[15:8];
            4'd1:    rd_r_data = {r_af[7:4], 4'b0000};
            4'd2:    rd_r_data = r_bc[15:8];
            4'd3:    rd_r_data = r_bc[7:0];
            4'd4:    rd_r_data = r_de[15:8];
            4'd5:    rd_r_data = r_de[7:0];
            4'd6:    rd_r_data = r_hl[15:8];
            4'd7:    rd_r_data = r_hl[7:0];
            4'd8:    rd_r_data = r_wz[15:8];
            4'd9:    rd_r_data = r_wz[7:0];
            4'd10:   rd_r_data = r_sp[15:8];
            4'd11:   rd_r_data = r_sp[7:0];
            4'd12:   rd_r_data = r_pc[15:8];
            4'd13:   rd_r_data = r_pc[7:0];
            default: rd_r_data = 8'h00;
        endcase
    end

    assign w_idu_res = (idu_op == 2'd0) ? (idu_addr + 16'd1) : (idu_addr - 16'd1);
    assign w_idu_wr  = idu_en && ((idu_op == 2'd0) || (idu_op == 2'd1));

    // Register next-state: later assignments win (wr_r < flags < wr_rr < IDU < restore).
    // AF/BC/DE/HL are frozen to external writers while a transfer is running.
    always_comb begin
        w_af_d = r_af;
        w_bc_d = r_bc;
        w_de_d = r_de;
        w_hl_d = r_hl;
        w_sp_d = r_sp;
        w_pc_d = r_pc;
        w_wz_d = r_wz;

        if (wr_r_en) begin
            case (wr_r_sel)
                4'd0:    if (w_idle) w_af_d[15:8] = wr_r_data;
                4'd1:    if (w_idle) w_af_d[7:4] = wr_r_data[7:4];
                4'd2:    if (w_idle) w_bc_d[15:8] = wr_r_data;
                4'd3:    if (w_idle) w_bc_d[7:0] = wr_r_data;
                4'd4:    if (w_idle) w_de_d[15:8] = wr_r_data;
                4'd5:    if (w_idle) w_de_d[7:0] = wr_r_data;
                4'd6:    if (w_idle) w_hl_d[15:8] = wr_r_data;
                4'd7:    if (w_idle) w_hl_d[7:0] = wr_r_data;
                4'd8:    w_wz_d[15:8] = wr_r_data;
                4'd9:    w_wz_d[7:0] = wr_r_data;
                4'd10:   w_sp_d[15:8] = wr_r_data;
                4'd11:   w_sp_d[7:0] = wr_r_data;
                4'd12:   w_pc_d[15:8] = wr_r_data;
                4'd13:   w_pc_d[7:0] = wr_r_data;
                default: ;
            endcase
        end

        // mask_n bit low selects the flag for update; flags_in[3] is Z (F[7])
        if (flags_we && w_idle) begin
            for (int i = 0; i < 4; i++) begin
                if (!flags_mask_n[i]) w_af_d[4+i] = flags_in[i];
            end
        end

        if (wr_rr_en) begin
            case (wr_rr_sel)
                3'd0:    if (w_idle) w_af_d = wr_rr_data;
                3'd1:    if (w_idle) w_bc_d = wr_rr_data;
                3'd2:    if (w_idle) w_de_d = wr_rr_data;
                3'd3:    if (w_idle) w_hl_d = wr_rr_data;
                3'd4:    w_sp_d = wr_rr_data;
                3'd5:    w_pc_d = wr_rr_data;
                3'd6:    w_wz_d = wr_rr_data;
                default: ;
            endcase
        end

        if (w_idu_wr) begin
            case (idu_sel)
                3'd0:    if (w_idle) w_af_d = w_idu_res;
                3'd1:    if (w_idle) w_bc_d = w_idu_res;
                3'd2:    if (w_idle) w_de_d = w_idu_res;
                3'd3:    if (w_idle) w_hl_d = w_idu_res;
                3'd4:    w_sp_d = w_idu_res;
                3'd5:    w_pc_d = w_idu_res;
                3'd6:    w_wz_d = w_idu_res;
                default: ;
            endcase
        end

        if (r_state == StRestore) begin
            case (r_k)
                2'd0:    w_af_d = w_stk_rd;
                2'd1:    w_bc_d = w_stk_rd;
                2'd2:    w_de_d = w_stk_rd;
                default: w_hl_d = w_stk_rd;
            endcase
        end

        w_af_d[3:0] = 4'b0000;
    end

    // Register file state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_af <= '0;
            r_bc <= '0;
            r_de <= '0;
            r_hl <= '0;
            r_sp <= '0;
            r_pc <= '0;
            r_wz <= '0;
        end else begin
            r_af <= w_af_d;
            r_bc <= w_bc_d;
            r_de <= w_de_d;
            r_hl <= w_hl_d;
            r_sp <= w_sp_d;
            r_pc <= w_pc_d;
            r_wz <= w_wz_d;
        end
    end

    // Stack storage: one pair per SAVE cycle, not reset
    always_ff @(posedge clk) begin
        if (!rst && (r_state == StSave)) begin
            r_stack[w_wr_idx][r_k] <= w_pair[{1'b0, r_k}];
        end
    end

    // Context FSM next-state and handshake pulses
    always_comb begin
        w_state_d = r_state;
        w_k_d     = r_k;
        w_level_d = r_level;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        case (r_state)
            StIdle: begin
                if (ctx_save_req) begin
                    if (w_full) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_state_d = StSave;
                        w_k_d     = 2'd0;
                    end
                end else if (ctx_restore_req) begin
                    if (w_empty) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_state_d = StRestore;
                        w_k_d     = 2'd0;
                    end
                end
            end
            StSave: begin
                w_k_d = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_state_d = StIdle;
                    w_level_d = r_level + LVL_W'(1);
                    w_done_d  = 1'b1;
                end
            end
            StRestore: begin
                w_k_d = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_state_d = StIdle;
                    w_level_d = w_level_m1;
                    w_done_d  = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Context FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_k     <= 2'd0;
            r_level <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_k     <= w_k_d;
            r_level <= w_level_d;
            r_done  <= w_done_d;
            r_err   <= w_err_d;
        end
    end

    assign ctx_busy  = !w_idle;
    assign ctx_done  = r_done;
    assign ctx_err   = r_err;
    assign ctx_full  = w_full;
    assign ctx_empty = w_empty;
    assign ctx_level = r_level;
    assign A_out     = r_af[15:8];
    assign flags_out = r_af[7:4];

endmodule
